lcd_32_to_64_bits_packer: RTL and testbench
===========================================

// Module: lcd_32_to_64_bits_packer
// PURPOSE
//  Channelised Avalon-ST width adapter: packs 32-bit input beats into 64-bit output beats.
//  Mirror of the 64->32 unpacker in the LCD picture-viewer datapath; feeds the wide side.
//  Per-channel packing state (held half-word plus flags) lives in a zero-on-reset state table.
//  Symbol order is big-endian: the first input beat lands in out_data[63:32].
// PARAMETERS
//  CHANNELS       2   number of independent channels; state table depth.
//  CHANNEL_WIDTH  1   width of in_channel/out_channel; CHANNELS <= 2**CHANNEL_WIDTH.
// PORTS
//  clk                input   1   single clock.
//  reset_n            input   1   asynchronous, active-low reset.
//  in_data            input   32  input symbols, 4 x 8 bit.
//  in_valid           input   1   input beat valid.
//  in_ready           output  1   input beat accepted when in_valid & in_ready.
//  in_startofpacket   input   1   first beat of packet.
//  in_endofpacket     input   1   last beat of packet.
//  in_empty           input   2   empty symbols on eop beat; ignored on other beats.
//  in_channel         input   CW  channel of input beat.
//  out_data           output  64  packed symbols.
//  out_valid          output  1   output beat valid.
//  out_ready          input   1   downstream ready.
//  out_startofpacket  output  1   first beat of packet.
//  out_endofpacket    output  1   last beat of packet.
//  out_empty          output  3   empty symbols on eop beat; 0 otherwise.
//  out_channel        output  CW  channel of output beat.
//  protocol_error     output  1   1-cycle pulse: sop received while channel held a half-word.
// BEHAVIOUR
//  Reset: all outputs 0 (out_valid=0, protocol_error=0, in_ready=0). The state table is
//   cleared to EMPTY by a walk over CHANNELS entries, one entry per cycle.
//   in_ready stays 0 until the walk completes, then follows the handshake rule.
//  Handshake: in_ready = ~clearing & (~out_valid | out_ready). Single output register.
//   The output register holds all out_* values stable while out_valid & ~out_ready.
//  Per-channel FSM, with states EMPTY and HALF. Entry fields: hold[31:0], hold_sop.
//   EMPTY, accepted beat, ~eop: hold<=in_data; hold_sop<=in_sop; ->HALF; no output.
//   EMPTY, accepted beat, eop: emit {in_data,32'h0}; sop=in_sop; eop=1;
//    out_empty=in_empty+3'd4; stay EMPTY.
//   HALF, accepted beat, ~sop: emit {hold,in_data}; sop=hold_sop; eop=in_eop;
//    out_empty = in_eop ? {1'b0,in_empty} : 0; ->EMPTY.
//   HALF, accepted beat, sop: pulse protocol_error; drop hold; process the beat as EMPTY.
//  Latency: out_valid rises on the cycle after acceptance of the completing beat.
//  Back-to-back beats on the same channel on consecutive cycles must see the just-written
//   state; the table is register-based, or read-bypassed, to guarantee this.
//  Channels interleave freely; each channel packs independently.
//  in_channel >= CHANNELS: the beat is accepted and dropped, and protocol_error pulses.
//  Reset asserted mid-packet: held halves are discarded and the pending output beat is lost.
// STRUCTURE
//  Shared package lcd_adapter_pkg:
//   - SYMBOL_W=8;
//   - state encoding ST_EMPTY/ST_HALF;
//   - typedef of the state entry {state, hold_sop, hold[31:0]}.
//  Sub-module lcd_32_to_64_bits_state_table: CHANNELS-deep table with
//   clear-on-reset walk, write port, and combinational read with same-cycle write bypass.
//  The top level holds the FSM next-state logic and the output register.
// TESTING
//  Reset release, CHANNELS=2: in_ready=0 for 2 cycles, then 1; out_valid=0 throughout.
//  ch0 beats A1B2C3D4(sop), 11223344(eop, empty=0) ->
//   out_data=A1B2C3D411223344, sop=1, eop=1, empty=0, channel=0.
//  ch1 single beat DEADBEEF, sop+eop, empty=1 ->
//   out_data=DEADBEEF00000000, empty=5, channel=1.
//  Interleave ch0 W0, ch1 V0, ch0 W1, ch1 V1 -> outputs {W0,W1} on ch0, then {V0,V1} on ch1,
//   in that order.
//  out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and out_* stable;
//   no beat is lost after release.
//  ch0 sop beat, then a second sop beat before eop -> protocol_error pulses once;
//   the packet restarts from the second beat.

Source files
------------

// File: rtl/lcd_adapter_pkg.sv
// Shared types for the LCD Avalon-ST width adapters: symbol geometry and the
// per-channel packing state entry.
package lcd_adapter_pkg;

   localparam int SYMBOL_W    = 8;
   localparam int IN_SYMBOLS  = 4;
   localparam int OUT_SYMBOLS = 8;
   localparam int IN_W        = IN_SYMBOLS * SYMBOL_W;
   localparam int OUT_W       = OUT_SYMBOLS * SYMBOL_W;
   localparam int IN_EMPTY_W  = $clog2(IN_SYMBOLS);
   localparam int OUT_EMPTY_W = $clog2(OUT_SYMBOLS);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pk_state_e;

   // ST_EMPTY must encode as zero so that an all-zero entry is a cleared one.
   typedef struct packed {
      pk_state_e        state;
      logic             hold_sop;
      logic [IN_W-1:0]  hold;
   } pk_entry_t;

   // A lone eop beat fills only the upper half, so the lower four symbols are empty too.
   function automatic logic [OUT_EMPTY_W-1:0] lone_beat_empty(input logic [IN_EMPTY_W-1:0] e);
      return {1'b0, e} + OUT_EMPTY_W'(IN_SYMBOLS);
   endfunction

endpackage

// File: rtl/lcd_32_to_64_bits_packer_if.sv
// Avalon-ST beat bundle, sized per side of the adapter.
interface lcd_32_to_64_bits_packer_if #(
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2,
   parameter int CH_W    = 1
) ();

   logic [DATA_W-1:0]  data;
   logic               valid;
   logic               ready;
   logic               startofpacket;
   logic               endofpacket;
   logic [EMPTY_W-1:0] empty;
   logic [CH_W-1:0]    channel;

   modport master (
      output data, valid, startofpacket, endofpacket, empty, channel,
      input  ready
   );

   modport slave (
      input  data, valid, startofpacket, endofpacket, empty, channel,
      output ready
   );

endinterface

// File: rtl/lcd_32_to_64_bits_state_table.sv
// Per-channel packing state table: cleared by a walk after reset, written one
// cycle after the deciding beat, read combinationally with bypass of that write.
module lcd_32_to_64_bits_state_table
   import lcd_adapter_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int CHANNEL_WIDTH = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [CHANNEL_WIDTH-1:0] i_rd_ch,
   output pk_entry_t                o_rd_entry,
   input  logic                     i_wr_en,
   input  logic [CHANNEL_WIDTH-1:0] i_wr_ch,
   input  pk_entry_t                i_wr_entry,
   output logic                     o_clearing
);

   logic                     r_clearing;
   logic [CHANNEL_WIDTH-1:0] r_clr_cnt;
   pk_entry_t                r_tab [CHANNELS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clearing <= 1'b1;
         r_clr_cnt  <= CHANNEL_WIDTH'(CHANNELS - 1);
      end else if (r_clearing) begin
         if (r_clr_cnt == '0) begin
            r_clearing <= 1'b0;
         end else begin
            r_clr_cnt <= r_clr_cnt - 1'b1;
         end
      end
   end

   // Storage has no reset of its own; the walk is what empties it.
   always_ff @(posedge clk) begin
      if (r_clearing) begin
         r_tab[r_clr_cnt] <= '0;
      end else if (i_wr_en) begin
         r_tab[i_wr_ch] <= i_wr_entry;
      end
   end

   assign o_rd_entry = (i_wr_en && (i_wr_ch == i_rd_ch)) ? i_wr_entry : r_tab[i_rd_ch];
   assign o_clearing = r_clearing;

endmodule

// File: rtl/lcd_32_to_64_bits_packer.sv
// Channelised Avalon-ST packer: two 32-bit beats into one 64-bit beat, big-endian.
//   state    | meaning
//   ST_EMPTY | channel holds nothing; next beat starts a word (or emits alone on eop)
//   ST_HALF  | channel holds the upper half-word and its sop flag
module lcd_32_to_64_bits_packer
   import lcd_adapter_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int CHANNEL_WIDTH = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   lcd_32_to_64_bits_packer_if.slave  in_st,
   lcd_32_to_64_bits_packer_if.master out_st,
   output logic                      protocol_error
);

   logic                     w_clearing;
   logic                     w_in_ready;
   logic                     w_acc;
   logic                     w_ch_ok;
   pk_entry_t                w_rd_entry;

   logic                     w_wr_en;
   pk_entry_t                w_wr_entry;
   logic                     w_emit;
   logic [OUT_W-1:0]         w_emit_data;
   logic                     w_emit_sop;
   logic                     w_emit_eop;
   logic [OUT_EMPTY_W-1:0]   w_emit_empty;
   logic                     w_perr;

   logic                     r_wr_en;
   logic [CHANNEL_WIDTH-1:0] r_wr_ch;
   pk_entry_t                r_wr_entry;

   logic                     r_out_valid;
   logic [OUT_W-1:0]         r_out_data;
   logic                     r_out_sop;
   logic                     r_out_eop;
   logic [OUT_EMPTY_W-1:0]   r_out_empty;
   logic [CHANNEL_WIDTH-1:0] r_out_channel;
   logic                     r_perr;

   assign w_in_ready = ~w_clearing & (~r_out_valid | out_st.ready);
   assign w_acc      = in_st.valid & w_in_ready;

   generate
      if (CHANNELS < (1 << CHANNEL_WIDTH)) begin : g_ch_range
         assign w_ch_ok = (int'(in_st.channel) < CHANNELS);
      end else begin : g_ch_full
         assign w_ch_ok = 1'b1;
      end
   endgenerate

   lcd_32_to_64_bits_state_table #(
      .CHANNELS      (CHANNELS),
      .CHANNEL_WIDTH (CHANNEL_WIDTH)
   ) u_state_table (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_rd_ch    (in_st.channel),
      .o_rd_entry (w_rd_entry),
      .i_wr_en    (r_wr_en),
      .i_wr_ch    (r_wr_ch),
      .i_wr_entry (r_wr_entry),
      .o_clearing (w_clearing)
   );

   always_comb begin
      w_wr_en      = 1'b0;
      w_wr_entry   = '0;
      w_emit       = 1'b0;
      w_emit_data  = '0;
      w_emit_sop   = 1'b0;
      w_emit_eop   = 1'b0;
      w_emit_empty = '0;
      w_perr       = 1'b0;
      if (w_acc) begin
         if (!w_ch_ok) begin
            w_perr = 1'b1;
         end else begin
            w_wr_en = 1'b1;
            if ((w_rd_entry.state == ST_HALF) && !in_st.startofpacket) begin
               w_emit       = 1'b1;
               w_emit_data  = {w_rd_entry.hold, in_st.data};
               w_emit_sop   = w_rd_entry.hold_sop;
               w_emit_eop   = in_st.endofpacket;
               w_emit_empty = in_st.endofpacket ? {1'b0, in_st.empty} : '0;
            end else begin
               // A sop landing on a held half abandons it and restarts the packet here.
               w_perr = (w_rd_entry.state == ST_HALF);
               if (in_st.endofpacket) begin
                  w_emit       = 1'b1;
                  w_emit_data  = {in_st.data, {IN_W{1'b0}}};
                  w_emit_sop   = in_st.startofpacket;
                  w_emit_eop   = 1'b1;
                  w_emit_empty = lone_beat_empty(in_st.empty);
               end else begin
                  w_wr_entry.state    = ST_HALF;
                  w_wr_entry.hold_sop = in_st.startofpacket;
                  w_wr_entry.hold     = in_st.data;
               end
            end
         end
      end
   end

   // Table write is staged one cycle; the table's read bypass hides the delay.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_en    <= 1'b0;
         r_wr_ch    <= '0;
         r_wr_entry <= '0;
      end else begin
         r_wr_en    <= w_wr_en;
         r_wr_ch    <= in_st.channel;
         r_wr_entry <= w_wr_entry;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_sop     <= 1'b0;
         r_out_eop     <= 1'b0;
         r_out_empty   <= '0;
         r_out_channel <= '0;
         r_perr        <= 1'b0;
      end else begin
         r_perr <= w_perr;
         if (w_emit) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_emit_data;
            r_out_sop     <= w_emit_sop;
            r_out_eop     <= w_emit_eop;
            r_out_empty   <= w_emit_empty;
            r_out_channel <= in_st.channel;
         end else if (out_st.ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_st.ready          = w_in_ready;
   assign out_st.valid         = r_out_valid;
   assign out_st.data          = r_out_data;
   assign out_st.startofpacket = r_out_sop;
   assign out_st.endofpacket   = r_out_eop;
   assign out_st.empty         = r_out_empty;
   assign out_st.channel       = r_out_channel;
   assign protocol_error       = r_perr;

endmodule

// File: tb/tb_lcd_32_to_64_bits_packer.sv
// Directed bench for the 32->64 packer with an expected-beat queue checked at the output.
module tb_lcd_32_to_64_bits_packer;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic        ch;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic protocol_error;

   always #5 clk = ~clk;

   lcd_32_to_64_bits_packer_if #(.DATA_W(32), .EMPTY_W(2), .CH_W(1)) in_if ();
   lcd_32_to_64_bits_packer_if #(.DATA_W(64), .EMPTY_W(3), .CH_W(1)) out_if ();

   lcd_32_to_64_bits_packer #(.CHANNELS(2), .CHANNEL_WIDTH(1)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_st          (in_if),
      .out_st         (out_if),
      .protocol_error (protocol_error)
   );

   int   n_assert = 0;
   int   n_fail   = 0;
   int   perr_cnt = 0;
   exp_t sb[$];

   function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   function automatic void expect_beat(input logic [63:0] d, input logic s, input logic e,
                                       input logic [2:0] em, input logic ch);
      exp_t x;
      x.data = d; x.sop = s; x.eop = e; x.empty = em; x.ch = ch;
      sb.push_back(x);
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (reset_n && protocol_error) perr_cnt++;
      if (reset_n && out_if.valid && out_if.ready) begin
         if (sb.size() == 0) begin
            check("out_unexpected", 64'(out_if.valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("out_data",    out_if.data,                 e.data);
            check("out_sop",     64'(out_if.startofpacket),   64'(e.sop));
            check("out_eop",     64'(out_if.endofpacket),     64'(e.eop));
            check("out_empty",   64'(out_if.empty),           64'(e.empty));
            check("out_channel", 64'(out_if.channel),         64'(e.ch));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
   task automatic send(input logic [31:0] d, input logic s, input logic e,
                       input logic [1:0] em, input logic ch);
      bit acc;
      int n;
      in_if.data          = d;
      in_if.startofpacket = s;
      in_if.endofpacket   = e;
      in_if.empty         = em;
      in_if.channel       = ch;
      in_if.valid         = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_if.ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_if.valid = 1'b0;
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_queue", 64'(sb.size()), 64'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      in_if.valid         = 1'b0;
      in_if.data          = '0;
      in_if.startofpacket = 1'b0;
      in_if.endofpacket   = 1'b0;
      in_if.empty         = '0;
      in_if.channel       = '0;
      out_if.ready        = 1'b1;
      reset_n             = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(in_if.ready),    64'd0);
      check("rst_out_valid", 64'(out_if.valid),   64'd0);
      check("rst_perr",      64'(protocol_error), 64'd0);

      reset_n = 1'b1;
      check("clr_c0_in_ready", 64'(in_if.ready), 64'd0);
      @(posedge clk); #1;
      check("clr_c1_in_ready",  64'(in_if.ready),  64'd0);
      check("clr_c1_out_valid", 64'(out_if.valid), 64'd0);
      @(posedge clk); #1;
      check("clr_done_in_ready", 64'(in_if.ready),  64'd1);
      check("clr_done_out_valid", 64'(out_if.valid), 64'd0);

      // two-beat packet on ch0
      send(32'hA1B2C3D4, 1'b1, 1'b0, 2'd0, 1'b0);
      expect_beat(64'hA1B2C3D4_11223344, 1'b1, 1'b1, 3'd0, 1'b0);
      send(32'h11223344, 1'b0, 1'b1, 2'd0, 1'b0);

      // single-beat packet on ch1
      expect_beat(64'hDEADBEEF_00000000, 1'b1, 1'b1, 3'd5, 1'b1);
      send(32'hDEADBEEF, 1'b1, 1'b1, 2'd1, 1'b1);

      // interleaved channels
      send(32'h01010101, 1'b1, 1'b0, 2'd0, 1'b0);
      send(32'h02020202, 1'b1, 1'b0, 2'd0, 1'b1);
      expect_beat(64'h01010101_03030303, 1'b1, 1'b1, 3'd2, 1'b0);
      send(32'h03030303, 1'b0, 1'b1, 2'd2, 1'b0);
      expect_beat(64'h02020202_04040404, 1'b1, 1'b1, 3'd3, 1'b1);
      send(32'h04040404, 1'b0, 1'b1, 2'd3, 1'b1);

      // four beats back-to-back on ch1: middle word has neither eop nor empty
      send(32'h10000001, 1'b1, 1'b0, 2'd0, 1'b1);
      expect_beat(64'h10000001_10000002, 1'b1, 1'b0, 3'd0, 1'b1);
      send(32'h10000002, 1'b0, 1'b0, 2'd3, 1'b1);
      send(32'h10000003, 1'b0, 1'b0, 2'd0, 1'b1);
      expect_beat(64'h10000003_10000004, 1'b0, 1'b1, 3'd0, 1'b1);
      send(32'h10000004, 1'b0, 1'b1, 2'd0, 1'b1);

      // odd-length packet on ch0: trailing lone beat, maximum empty
      send(32'h20000001, 1'b1, 1'b0, 2'd0, 1'b0);
      expect_beat(64'h20000001_20000002, 1'b1, 1'b0, 3'd0, 1'b0);
      send(32'h20000002, 1'b0, 1'b0, 2'd0, 1'b0);
      expect_beat(64'h20000003_00000000, 1'b0, 1'b1, 3'd7, 1'b0);
      send(32'h20000003, 1'b0, 1'b1, 2'd3, 1'b0);
      drain();

      // downstream stall with a further beat waiting
      out_if.ready = 1'b0;
      send(32'h55667788, 1'b1, 1'b0, 2'd0, 1'b0);
      expect_beat(64'h55667788_99AABBCC, 1'b1, 1'b1, 3'd0, 1'b0);
      send(32'h99AABBCC, 1'b0, 1'b1, 2'd0, 1'b0);
      expect_beat(64'hCAFEF00D_00000000, 1'b1, 1'b1, 3'd4, 1'b1);
      in_if.data          = 32'hCAFEF00D;
      in_if.startofpacket = 1'b1;
      in_if.endofpacket   = 1'b1;
      in_if.empty         = 2'd0;
      in_if.channel       = 1'b1;
      in_if.valid         = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready",  64'(in_if.ready),  64'd0);
         check("stall_out_valid", 64'(out_if.valid), 64'd1);
         check("stall_out_data",  out_if.data,       64'h55667788_99AABBCC);
         check("stall_out_ch",    64'(out_if.channel), 64'd0);
         @(posedge clk); #1;
      end
      out_if.ready = 1'b1;
      send(32'hCAFEF00D, 1'b1, 1'b1, 2'd0, 1'b1);
      drain();

      // sop arriving while ch0 holds a half-word
      check("perr_none_yet", 64'(perr_cnt), 64'd0);
      send(32'h30000001, 1'b1, 1'b0, 2'd0, 1'b0);
      send(32'h30000002, 1'b1, 1'b0, 2'd0, 1'b0);
      expect_beat(64'h30000002_30000003, 1'b1, 1'b1, 3'd1, 1'b0);
      send(32'h30000003, 1'b0, 1'b1, 2'd1, 1'b0);
      drain();
      repeat (2) @(posedge clk);
      #1;
      check("perr_once", 64'(perr_cnt), 64'd1);

      // reset mid-packet discards the held half
      send(32'h0BADC0DE, 1'b1, 1'b0, 2'd0, 1'b0);
      reset_n = 1'b0;
      #1;
      check("midrst_in_ready",  64'(in_if.ready),  64'd0);
      check("midrst_out_valid", 64'(out_if.valid), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_ready_back", 64'(in_if.ready), 64'd1);
      expect_beat(64'h13579BDF_00000000, 1'b0, 1'b1, 3'd4, 1'b0);
      send(32'h13579BDF, 1'b0, 1'b1, 2'd0, 1'b0);
      drain();

      repeat (3) @(posedge clk);
      #1;
      check("end_queue_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
